pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
- Parametrised next-generation PC generator for the mmm front end; drives fetch addresses to the fetch stage through a valid/ready handshake.
- Generalises single-instruction PC+4 generation to fetch blocks of FETCH_BYTES.
- Adds exception/trap redirect, correct not-taken recovery from the resolved branch PC, debug halt, epoch tagging and a flush pulse for downstream squash.

Parameters:
- XLEN, 32, address width.
- BOOT_ADDR, mmm_pkg::BOOT_PC, PC loaded at reset.
- FETCH_BYTES, 4, bytes per fetch block. Power of two, >= 4.
- EPOCH_W, 2, width of the redirect epoch counter.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- except_req_i  in  1  exception/trap/xret redirect request
- except_target_i  in  XLEN  trap/return target
- res_mispredict_i  in  1  branch unit reports misprediction
- res_taken_i  in  1  resolved direction of the mispredicted branch
- res_target_i  in  XLEN  resolved taken target
- res_pc_i  in  XLEN  PC of the resolved branch
- pred_taken_i  in  1  predictor says the current fetch block redirects
- pred_target_i  in  XLEN  predicted target
- halt_i  in  1  debug/stall halt request
- fetch_ready_i  in  1  fetch stage accepts pc_o
- pc_valid_o  out  1  pc_o is a valid fetch request
- pc_o  out  XLEN  current fetch address
- epoch_o  out  EPOCH_W  epoch of current fetch stream
- flush_o  out  1  one-cycle squash pulse

Behaviour:
- Single clock clk_i; reset rst_n_i is asynchronous, active-low. All state lives in flops on posedge clk_i or negedge rst_n_i.
- Reset values: pc_o=BOOT_ADDR, pc_valid_o=0, epoch_o=0, flush_o=0, FSM=BOOT.
- FSM states:
  - BOOT: pc_valid_o=0. Next cycle -> HALTED if halt_i, else RUN.
  - RUN: pc_valid_o=1.
  - HALTED: pc_valid_o=0, PC held.
- Handshake: fire = pc_valid_o & fetch_ready_i. pc_o and epoch_o are stable while pc_valid_o=1 and fetch_ready_i=0, unless a redirect occurs.
- Next-PC priority, evaluated every cycle in every state except BOOT:
  - 1) except_req_i -> except_target_i.
  - 2) res_mispredict_i -> res_taken_i ? res_target_i : seq(res_pc_i).
  - 3) In RUN with fire and pred_taken_i -> pred_target_i.
  - 4) In RUN with fire -> seq(pc_o).
  - 5) Otherwise hold.
- seq(a) = (a & ~(FETCH_BYTES-1)) + FETCH_BYTES, mod 2^XLEN. Wrap from the top block to 0 is legal.
- All loaded targets have bits [1:0] forced to 0.
- Redirect (1 or 2):
  - Takes effect next cycle regardless of fetch_ready_i.
  - epoch_o increments, wrapping mod 2^EPOCH_W.
  - flush_o=1 for exactly that next cycle, coincident with the redirected pc_o.
  - Back-to-back redirects each increment the epoch and keep flush_o high.
- Prediction inputs are ignored when there is no fire.
- RUN -> HALTED when halt_i=1 and no redirect. A fire in that same cycle still advances the PC.
- HALTED -> RUN when halt_i=0. pc_valid_o rises the next cycle with the held PC.
- A redirect in HALTED updates pc_o, epoch_o and flush_o but stays HALTED while halt_i=1.
- Reset asserted mid-operation returns all outputs to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset release, BOOT_ADDR=0x100, FETCH_BYTES=8, fetch_ready_i=1 -> pc_valid_o=0 in the first cycle, then pc_o sequence 0x100, 0x108, 0x110.
- fetch_ready_i=0 for 3 cycles at pc_o=0x110 -> pc_o stays 0x110 with pc_valid_o=1; one cycle after ready returns, pc_o=0x118.
- pred_taken_i=1, pred_target_i=0x203 on fire -> pc_o=0x200, flush_o=0, epoch_o unchanged. Same inputs with fetch_ready_i=0 -> pc_o held.
- Same cycle: except_req_i target 0x800, res_mispredict_i, pred_taken_i -> pc_o=0x800, epoch 0->1, flush_o high for exactly one cycle.
- res_mispredict_i=1, res_taken_i=0, res_pc_i=0x1FC, FETCH_BYTES=8 -> pc_o=0x200; a second mispredict the next cycle -> epoch 3->0 with flush_o high 2 cycles.
- pc_o=0xFFFFFFF8, fire, no prediction -> pc_o=0x0. Also: halt_i=1 -> pc_valid_o=0 and PC held; except in HALTED to 0x40 -> pc_o=0x40, still halted; halt_i=0 -> valid with 0x40. Also: async reset mid-run -> outputs return to reset values before the next edge.

Source files
------------

// File: rtl/pc_gen_unit.sv
// ============================================================================
// Module   : pc_gen_unit (with mmm_pkg)
// Brief    : Front-end fetch PC generator with redirect, epoch and halt support.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmm_pkg;
  localparam logic [31:0] BOOT_PC = 32'h0000_0000;
endpackage

module pc_gen_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR   = mmm_pkg::BOOT_PC,
  parameter int              FETCH_BYTES = 4,
  parameter int              EPOCH_W     = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               except_req_i,
  input  logic [XLEN-1:0]    except_target_i,
  input  logic               res_mispredict_i,
  input  logic               res_taken_i,
  input  logic [XLEN-1:0]    res_target_i,
  input  logic [XLEN-1:0]    res_pc_i,
  input  logic               pred_taken_i,
  input  logic [XLEN-1:0]    pred_target_i,
  input  logic               halt_i,
  input  logic               fetch_ready_i,
  output logic               pc_valid_o,
  output logic [XLEN-1:0]    pc_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic               flush_o
);

  localparam logic [XLEN-1:0] BLK_MASK   = ~(XLEN'(FETCH_BYTES - 1));
  localparam logic [XLEN-1:0] BLK_STEP   = XLEN'(FETCH_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic                flush_q, flush_d;
  logic                fire;
  logic                redirect;

  // Start of the next fetch block; wraps past the top of the address space.
  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] a);
    return (a & BLK_MASK) + BLK_STEP;
  endfunction

  assign fire     = (state_q == S_RUN) & fetch_ready_i;
  assign redirect = except_req_i | res_mispredict_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;
    flush_d = 1'b0;

    if (state_q == S_BOOT) begin
      state_d = halt_i ? S_HALTED : S_RUN;
    end else begin
      if (except_req_i) begin
        pc_d = except_target_i & ALIGN_MASK;
      end else if (res_mispredict_i) begin
        pc_d = res_taken_i ? (res_target_i & ALIGN_MASK) : seq_pc(res_pc_i);
      end else if (fire && pred_taken_i) begin
        pc_d = pred_target_i & ALIGN_MASK;
      end else if (fire) begin
        pc_d = seq_pc(pc_q);
      end

      if (redirect) begin
        epoch_d = epoch_q + EPOCH_W'(1);
        flush_d = 1'b1;
      end

      // A redirect keeps RUN alive so the new stream is issued promptly.
      if (state_q == S_RUN) begin
        if (halt_i && !redirect) state_d = S_HALTED;
      end else begin
        if (!halt_i) state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_BOOT;
      pc_q    <= BOOT_ADDR;
      epoch_q <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      flush_q <= flush_d;
    end
  end

  assign pc_valid_o = (state_q == S_RUN);
  assign pc_o       = pc_q;
  assign epoch_o    = epoch_q;
  assign flush_o    = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen_unit.sv
// ============================================================================
// Module   : tb_pc_gen_unit
// Brief    : Scoreboard bench for pc_gen_unit against a cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_gen_unit;

  localparam int          XLEN = 32;
  localparam int          FB   = 8;
  localparam int          EW   = 2;
  localparam logic [31:0] BOOT = 32'h100;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ex = 1'b0, mis = 1'b0, tk = 1'b0, pt = 1'b0, halt = 1'b0, rdy = 1'b0;
  logic [31:0]     ext = '0, rtgt = '0, rpc = '0, ptgt = '0;
  logic            pc_valid;
  logic [31:0]     pc;
  logic [EW-1:0]   epoch;
  logic            flush;

  typedef struct packed {
    logic          v;
    logic [31:0]   pc;
    logic [EW-1:0] ep;
    logic          fl;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;

  int          m_mode;
  logic [31:0] m_pc;
  int          m_ep;
  bit          m_fl;

  pc_gen_unit #(
    .XLEN(XLEN), .BOOT_ADDR(BOOT), .FETCH_BYTES(FB), .EPOCH_W(EW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .except_req_i(ex), .except_target_i(ext),
    .res_mispredict_i(mis), .res_taken_i(tk), .res_target_i(rtgt), .res_pc_i(rpc),
    .pred_taken_i(pt), .pred_target_i(ptgt),
    .halt_i(halt), .fetch_ready_i(rdy),
    .pc_valid_o(pc_valid), .pc_o(pc), .epoch_o(epoch), .flush_o(flush)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] m_seq(input logic [31:0] a);
    longint unsigned x;
    x = (longint'(a) / FB) * FB + FB;
    x = x % 64'h1_0000_0000;
    return x[31:0];
  endfunction

  function automatic logic [31:0] m_align(input logic [31:0] a);
    return (a / 4) * 4;
  endfunction

  function automatic exp_t m_rec();
    exp_t e;
    e.v  = (m_mode == M_RUN);
    e.pc = m_pc;
    e.ep = EW'(m_ep);
    e.fl = m_fl;
    return e;
  endfunction

  task automatic model_reset();
    m_mode = M_BOOT;
    m_pc   = BOOT;
    m_ep   = 0;
    m_fl   = 0;
  endtask

  // Advance the reference one clock using the inputs currently driven.
  task automatic model_step();
    bit redir, fire;
    redir = ex || mis;
    fire  = (m_mode == M_RUN) && rdy;
    if (m_mode == M_BOOT) begin
      m_mode = halt ? M_HALT : M_RUN;
      m_fl   = 0;
    end else begin
      if (ex)                m_pc = m_align(ext);
      else if (mis)          m_pc = tk ? m_align(rtgt) : m_seq(rpc);
      else if (fire && pt)   m_pc = m_align(ptgt);
      else if (fire)         m_pc = m_seq(m_pc);
      if (redir) m_ep = (m_ep + 1) % (1 << EW);
      m_fl = redir;
      if (m_mode == M_RUN) m_mode = (halt && !redir) ? M_HALT : M_RUN;
      else                 m_mode = halt ? M_HALT : M_RUN;
    end
  endtask

  task automatic drive(input bit i_ex, input logic [31:0] i_ext,
                       input bit i_mis, input bit i_tk, input logic [31:0] i_rtgt,
                       input logic [31:0] i_rpc, input bit i_pt, input logic [31:0] i_ptgt,
                       input bit i_halt, input bit i_rdy);
    @(negedge clk);
    ex = i_ex; ext = i_ext; mis = i_mis; tk = i_tk; rtgt = i_rtgt; rpc = i_rpc;
    pt = i_pt; ptgt = i_ptgt; halt = i_halt; rdy = i_rdy;
    model_step();
    q.push_back(m_rec());
  endtask

  task automatic idle(input bit i_rdy, input bit i_halt);
    drive(0, 0, 0, 0, 0, 0, 0, 0, i_halt, i_rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (pc_valid !== 1'b0 || pc !== BOOT || epoch !== '0 || flush !== 1'b0) begin
      fails++;
      $display("FAIL %s: got v=%0b pc=%h ep=%0d fl=%0b, expected v=0 pc=%h ep=0 fl=0",
               tag, pc_valid, pc, epoch, flush, BOOT);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    q.delete();
    q.push_back(m_rec());
    mon_en = 1'b1;
  endtask

  // Monitor: one expected record per cycle, compared away from the rising edge.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL cyc%0d scoreboard: DUT output with no expected record", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (pc_valid !== e.v || pc !== e.pc || epoch !== e.ep || flush !== e.fl) begin
          fails++;
          $display("FAIL cyc%0d outputs: got v=%0b pc=%h ep=%0d fl=%0b, expected v=%0b pc=%h ep=%0d fl=%0b",
                   cyc, pc_valid, pc, epoch, flush, e.v, e.pc, e.ep, e.fl);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_hold");
    release_reset();

    // Boot then sequential blocks 0x100, 0x108, 0x110.
    idle(1, 0);
    idle(1, 0);
    idle(1, 0);
    // Back-pressure holds 0x110, then advances to 0x118.
    repeat (3) idle(0, 0);
    idle(1, 0);
    // Predicted taken on fire, then ignored without fire.
    drive(0, 0, 0, 0, 0, 0, 1, 32'h203, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h403, 0, 0);
    // All three sources at once: exception wins.
    drive(1, 32'h800, 1, 1, 32'h600, 32'h500, 1, 32'h300, 0, 1);
    idle(0, 0);
    idle(0, 0);
    // Epoch to 2, then not-taken mispredicts from 0x1FC (epoch 3 then wrap to 0).
    drive(1, 32'h900, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 32'h1FC, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 32'h1FC, 0, 0, 0, 1);
    idle(0, 0);
    // Top-of-space wrap.
    drive(1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    idle(0, 0);
    // Halt with a fire in the same cycle, exception while halted, resume.
    idle(1, 1);
    idle(1, 1);
    drive(1, 32'h41, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1, 1);
    idle(1, 0);
    idle(1, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r_ex, r_mis, r_pt, r_halt, r_rdy;
      r_ex   = ($urandom_range(0, 15) == 0);
      r_mis  = ($urandom_range(0, 9) == 0);
      r_pt   = ($urandom_range(0, 2) == 0);
      r_halt = ($urandom_range(0, 11) == 0);
      r_rdy  = ($urandom_range(0, 3) != 0);
      drive(r_ex, $urandom, r_mis, $urandom_range(0, 1) == 1, $urandom,
            ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom,
            r_pt, $urandom, r_halt, r_rdy);
    end
    idle(1, 0);
    idle(1, 0);

    // Asynchronous reset between edges.
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q.delete();
    release_reset();
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, $urandom, $urandom,
            $urandom_range(0, 2) == 0, $urandom,
            $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending records, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
